// File: rtl/usb_rx_router.sv
// Host-to-peripheral demultiplexer: buffers FT601 read words in a small FIFO and
// strobes each one, in order, to the peripheral addressed by its top bits.
module usb_rx_router #(
    parameter int WIDTH           = 32,
    parameter int NUM_PERIPHERALS = 8,
    parameter int ADDR_WIDTH      = 3,
    parameter int DEPTH           = 4,
    parameter int SKID            = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [WIDTH-1:0]           in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [NUM_PERIPHERALS-1:0] out_valid,
    input  logic [NUM_PERIPHERALS-1:0] periph_tx_almost_full,
    input  logic                       stat_clr,
    output logic [15:0]                stall_count,
    output logic                       overflow,
    output logic                       bad_addr,
    output logic                       idle
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int NA = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0]           NUM_P     = (ADDR_WIDTH + 1)'(NUM_PERIPHERALS);
    localparam logic [CW-1:0]                 DEPTH_C   = CW'(DEPTH);
    localparam logic [CW-1:0]                 READY_LIM = CW'(DEPTH - SKID);
    localparam logic [NUM_PERIPHERALS-1:0]    ONE_HOT0  = NUM_PERIPHERALS'(1'b1);

    logic [WIDTH-1:0]           mem_q [DEPTH];
    logic [PW-1:0]              wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]              count_q, count_d;
    logic [WIDTH-1:0]           out_data_q, out_data_d;
    logic [NUM_PERIPHERALS-1:0] out_valid_q, out_valid_d;
    logic [15:0]                stall_q, stall_d;
    logic                       overflow_q, overflow_d;
    logic                       bad_addr_q, bad_addr_d;

    logic [WIDTH-1:0]      head_s;
    logic [ADDR_WIDTH-1:0] head_addr_s;
    logic [NA-1:0]         af_ext_s;
    logic                  has_head_s, bad_s, go_s, blocked_s, pop_s, push_s, drop_s;

    // Dispatch decision for the head word and push acceptance.
    always_comb begin
        head_s      = mem_q[rd_ptr_q];
        head_addr_s = head_s[WIDTH-1 -: ADDR_WIDTH];
        // Addresses beyond NUM_PERIPHERALS read as not-full; bad_s discards them first.
        af_ext_s    = NA'(periph_tx_almost_full);
        has_head_s  = (count_q != '0);
        bad_s       = has_head_s && ({1'b0, head_addr_s} >= NUM_P);
        go_s        = has_head_s && !bad_s && !af_ext_s[head_addr_s];
        blocked_s   = has_head_s && !bad_s && af_ext_s[head_addr_s];
        pop_s       = bad_s || go_s;
        push_s      = in_valid && ((count_q != DEPTH_C) || pop_s);
        drop_s      = in_valid && (count_q == DEPTH_C) && !pop_s;
    end

    // Next-state for pointers, occupancy, output register and status.
    always_comb begin
        wr_ptr_d = push_s ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop_s  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        if (go_s) begin
            out_data_d  = head_s;
            out_valid_d = ONE_HOT0 << head_addr_s;
        end else begin
            out_data_d  = out_data_q;
            out_valid_d = '0;
        end
        // Set events take priority over stat_clr.
        if (blocked_s) begin
            stall_d = (stall_q == 16'hFFFF) ? stall_q : stall_q + 16'd1;
        end else if (stat_clr) begin
            stall_d = 16'd0;
        end else begin
            stall_d = stall_q;
        end
        if (drop_s) begin
            overflow_d = 1'b1;
        end else if (stat_clr) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
        if (bad_s) begin
            bad_addr_d = 1'b1;
        end else if (stat_clr) begin
            bad_addr_d = 1'b0;
        end else begin
            bad_addr_d = bad_addr_q;
        end
    end

    // FIFO storage; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

    // Control and status registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            out_data_q  <= '0;
            out_valid_q <= '0;
            stall_q     <= 16'd0;
            overflow_q  <= 1'b0;
            bad_addr_q  <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            stall_q     <= stall_d;
            overflow_q  <= overflow_d;
            bad_addr_q  <= bad_addr_d;
        end
    end

    assign in_ready    = ~rst & (count_q < READY_LIM);
    assign idle        = (count_q == '0) & (out_valid_q == '0);
    assign out_data    = out_data_q;
    assign out_valid   = out_valid_q;
    assign stall_count = stall_q;
    assign overflow    = overflow_q;
    assign bad_addr    = bad_addr_q;
endmodule

// File: tb/tb_usb_rx_router.sv
// Scoreboard bench for usb_rx_router: a queue-level reference model predicts every
// strobe (word, target, cycle) and the status outputs; a negedge monitor compares.
module tb_usb_rx_router;
    localparam int N  = 8;
    localparam int D  = 4;
    localparam int SK = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out_data;
    logic [7:0]  out_valid;
    logic [7:0]  af;
    logic        stat_clr;
    logic [15:0] stall_count;
    logic        overflow, bad_addr, idle;

    logic [31:0] in6_data;
    logic        in6_valid, in6_ready;
    logic [31:0] out6_data;
    logic [5:0]  out6_valid, af6;
    logic [15:0] stall6;
    logic        ovf6, bad6, idle6;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [31:0] data;
        logic [7:0]  oh;
        int          cyc;
    } exp_t;
    exp_t        exp_q[$];
    logic [31:0] mq[$];
    int          m_stall;
    bit          m_ovf, m_bad, m_strobe;

    usb_rx_router dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .periph_tx_almost_full(af),
        .stat_clr(stat_clr), .stall_count(stall_count), .overflow(overflow),
        .bad_addr(bad_addr), .idle(idle)
    );

    usb_rx_router #(.NUM_PERIPHERALS(6)) dut6 (
        .clk(clk), .rst(rst), .in_data(in6_data), .in_valid(in6_valid), .in_ready(in6_ready),
        .out_data(out6_data), .out_valid(out6_valid), .periph_tx_almost_full(af6),
        .stat_clr(1'b0), .stall_count(stall6), .overflow(ovf6),
        .bad_addr(bad6), .idle(idle6)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: the FIFO is a plain queue; the head either leaves (bad address
    // or free target) or waits; an arriving word joins if the queue then has room.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            exp_q.delete();
            m_stall  = 0;
            m_ovf    = 1'b0;
            m_bad    = 1'b0;
            m_strobe = 1'b0;
        end else begin
            bit   left, blocked, bad_e, drop_e;
            int   a;
            exp_t e;
            left = 1'b0; blocked = 1'b0; bad_e = 1'b0; drop_e = 1'b0;
            m_strobe = 1'b0;
            if (mq.size() > 0) begin
                a = int'(mq[0][31:29]);
                if (a >= N) begin
                    bad_e = 1'b1;
                    left  = 1'b1;
                end else if (!af[a]) begin
                    e.data = mq[0];
                    e.oh   = 8'd1 << a;
                    e.cyc  = cyc + 1;
                    exp_q.push_back(e);
                    left     = 1'b1;
                    m_strobe = 1'b1;
                end else begin
                    blocked = 1'b1;
                end
            end
            if (left) void'(mq.pop_front());
            if (in_valid) begin
                if (mq.size() < D) mq.push_back(in_data);
                else drop_e = 1'b1;
            end
            if (blocked) m_stall = (m_stall < 65535) ? m_stall + 1 : 65535;
            else if (stat_clr) m_stall = 0;
            if (drop_e) m_ovf = 1'b1;
            else if (stat_clr) m_ovf = 1'b0;
            if (bad_e) m_bad = 1'b1;
            else if (stat_clr) m_bad = 1'b0;
        end
    end

    // Monitor: pops the scoreboard whenever a strobe appears and checks status outputs.
    always @(negedge clk) begin
        exp_t e;
        chk("in_ready", 32'(in_ready), 32'(!rst && (mq.size() < D - SK)));
        chk("idle", 32'(idle), 32'((mq.size() == 0) && !m_strobe));
        chk("stall_count", 32'(stall_count), 32'(m_stall));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("bad_addr", 32'(bad_addr), 32'(m_bad));
        if (out_valid != 8'h00) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe actual=%h expected=none (cycle %0d)", out_valid, cyc);
            end else begin
                e = exp_q.pop_front();
                chk("strobe_onehot", 32'(out_valid), 32'(e.oh));
                chk("strobe_data", out_data, e.data);
                chk("strobe_cycle", 32'(cyc), 32'(e.cyc));
            end
        end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            e = exp_q.pop_front();
            checks++;
            errors++;
            $display("FAIL missing_strobe actual=none expected=%h data=%h (cycle %0d)", e.oh, e.data, cyc);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; af = '0; stat_clr = 1'b0;
        in6_valid = 1'b0; in6_data = '0; af6 = '0;
        repeat (3) tick();
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_in_ready", 32'(in_ready), 32'h0);
        chk("rst_idle", 32'(idle), 32'h1);
        rst = 1'b0;
        #1;
        chk("release_in_ready", 32'(in_ready), 32'h1);

        // Single word to peripheral 2: strobe two edges after the push.
        in_valid = 1'b1; in_data = 32'h4000_00AA;
        tick();
        in_valid = 1'b0;
        tick();
        @(negedge clk);
        chk("single_onehot", 32'(out_valid), 32'h04);
        chk("single_data", out_data, 32'h4000_00AA);
        tick();
        @(negedge clk);
        chk("single_idle_after", 32'(idle), 32'h1);

        // Streaming one word per cycle to addresses 0..7.
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_data  = {3'(i), 29'($urandom)};
            tick();
        end
        in_valid = 1'b0;
        repeat (3) tick();

        // Head-of-line block on peripheral 5, skid absorption, then overflow.
        af = 8'h20;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = (i == 0) ? 32'hA000_0005 : {3'(i), 29'(i * 17)};
            tick();
        end
        in_valid = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        chk("blocked_overflow", 32'(overflow), 32'h1);
        chk("blocked_in_ready", 32'(in_ready), 32'h0);
        af = 8'h00;
        repeat (6) tick();
        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
        @(negedge clk);
        chk("clr_overflow", 32'(overflow), 32'h0);
        chk("clr_stall", 32'(stall_count), 32'h0);

        // Six-peripheral instance: address 7 discarded, address 1 delivered.
        in6_valid = 1'b1; in6_data = 32'hE000_0001;
        tick();
        in6_data = 32'h2000_0055;
        tick();
        in6_valid = 1'b0;
        @(negedge clk);
        chk("n6_bad_no_strobe", 32'(out6_valid), 32'h0);
        chk("n6_bad_addr", 32'(bad6), 32'h1);
        tick();
        @(negedge clk);
        chk("n6_onehot", 32'(out6_valid), 32'h02);
        chk("n6_data", out6_data, 32'h2000_0055);
        tick();
        @(negedge clk);
        chk("n6_idle", 32'(idle6), 32'h1);
        chk("n6_ready", 32'(in6_ready), 32'h1);
        chk("n6_no_overflow", 32'(ovf6), 32'h0);
        chk("n6_stall", 32'(stall6), 32'h0);

        // Randomized traffic, mostly honouring in_ready, with random backpressure.
        for (int i = 0; i < 1500; i++) begin
            in_valid = ($urandom_range(0, 3) != 0) && (in_ready || ($urandom_range(0, 7) == 0));
            in_data  = $urandom;
            af       = 8'($urandom & $urandom);
            stat_clr = ($urandom_range(0, 49) == 0);
            tick();
        end
        in_valid = 1'b0; af = 8'h00; stat_clr = 1'b0;
        repeat (8) tick();

        // Reset mid-stream with three words buffered and a strobe in flight.
        af = 8'h08;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = 32'h6000_0001 + 32'(i);
            tick();
        end
        af = 8'h00; in_data = 32'h2000_0009;
        tick();
        chk("pre_rst_strobe", 32'(out_valid), 32'h08);
        rst = 1'b1; in_valid = 1'b0;
        #1;
        chk("async_rst_out_valid", 32'(out_valid), 32'h0);
        chk("async_rst_idle", 32'(idle), 32'h1);
        chk("async_rst_in_ready", 32'(in_ready), 32'h0);
        repeat (2) tick();
        rst = 1'b0;
        repeat (5) tick();
        @(negedge clk);
        chk("post_rst_idle", 32'(idle), 32'h1);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
